// File: rtl/fb_sram_arb.sv
// Single-port frame buffer: display reads always win, then the clear engine, then draw writes.
// Define FB_SRAM_STATS_EN to build the saturating draw-stall counter on o_wr_stall_cnt.
module fb_sram_arb #(
  parameter int                    ADDR_WIDTH  = 19,
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    DEPTH       = 307200,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter                        MEMFILE     = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_clear_done,
  output logic [15:0]           o_wr_stall_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    rd_in_range, wr_in_range;
  logic                    mem_we, clr_step, clr_finish;
  logic [ADDR_WIDTH-1:0]   mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;

  assign rd_in_range = {1'b0, i_rd_addr} < DEPTH_A;
  assign wr_in_range = {1'b0, i_wr_addr} < DEPTH_A;

  // State register, clear address and done pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      clr_addr     <= '0;
      o_clear_done <= 1'b0;
    end else begin
      state        <= state_nx;
      o_clear_done <= clr_finish;
      if (state == S_IDLE)
        clr_addr <= '0;
      else if (clr_step)
        clr_addr <= clr_finish ? '0 : clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_clear)    state_nx = S_CLEAR;
      S_CLEAR: if (clr_finish) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output / arbitration: a pending read suppresses every array write this cycle
  always_comb begin
    mem_we   = 1'b0;
    mem_wa   = clr_addr;
    mem_wd   = CLEAR_VALUE;
    clr_step = 1'b0;
    case (state)
      S_CLEAR: begin
        if (!i_rd_req) begin
          mem_we   = 1'b1;
          clr_step = 1'b1;
        end
      end
      S_IDLE: begin
        if (i_wr_req && o_wr_ready && wr_in_range) begin
          mem_we = 1'b1;
          mem_wa = i_wr_addr;
          mem_wd = i_wr_data;
        end
      end
      default: ;
    endcase
  end

  assign clr_finish = clr_step && (clr_addr == LAST_A);
  assign o_busy     = (state == S_CLEAR);
  assign o_wr_ready = (state == S_IDLE) && !i_rd_req && i_rst_n;

  always_ff @(posedge i_clk) begin
    if (mem_we)
      mem[mem_wa[IDX_W-1:0]] <= mem_wd;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= i_rd_req;
      if (i_rd_req)
        o_rd_data <= rd_in_range ? mem[i_rd_addr[IDX_W-1:0]] : '0;
    end
  end

`ifdef FB_SRAM_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      stall_cnt <= '0;
    else if (i_wr_req && !o_wr_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign o_wr_stall_cnt = stall_cnt;
`else
  assign o_wr_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_sram_arb.sv
// Randomized bench for fb_sram_arb (DEPTH=16) against an array-based reference model.
// Honours FB_SRAM_STATS_EN for the expected stall count.
module tb_fb_sram_arb;

  localparam int AW  = 5;
  localparam int DW  = 12;
  localparam int DEP = 16;
  localparam logic [DW-1:0] CV = 12'h0F0;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_wr_req;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ready;
  logic          i_clear;
  logic          o_busy;
  logic          o_clear_done;
  logic [15:0]   o_wr_stall_cnt;

  fb_sram_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .CLEAR_VALUE(CV),
    .MEMFILE    ("")
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rd_req      (i_rd_req),
    .i_rd_addr     (i_rd_addr),
    .o_rd_valid    (o_rd_valid),
    .o_rd_data     (o_rd_data),
    .i_wr_req      (i_wr_req),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .o_wr_ready    (o_wr_ready),
    .i_clear       (i_clear),
    .o_busy        (o_busy),
    .o_clear_done  (o_clear_done),
    .o_wr_stall_cnt(o_wr_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain array plus "clear in progress" bookkeeping
  logic [DW-1:0] m_mem [DEP];
  bit            m_clearing;
  int            m_clr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_done;
  int            m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clearing = 1'b0;
    m_clr      = 0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_done     = 1'b0;
    m_stall    = 0;
  endtask

  task automatic check_regs();
    chk("rd_valid", 32'(o_rd_valid), 32'(m_valid));
    chk("rd_data", 32'(o_rd_data), 32'(m_data));
    chk("busy", 32'(o_busy), 32'(m_clearing));
    chk("clear_done", 32'(o_clear_done), 32'(m_done));
`ifdef FB_SRAM_STATS_EN
    chk("stall_cnt", 32'(o_wr_stall_cnt), 32'(m_stall));
`else
    chk("stall_cnt", 32'(o_wr_stall_cnt), 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, check ready, advance model, check registered outputs.
  task automatic cyc(input bit rd, input int ra, input bit wr, input int wa, input int wd, input bit clr);
    bit exp_ready;
    i_rd_req  = rd;
    i_rd_addr = AW'(ra);
    i_wr_req  = wr;
    i_wr_addr = AW'(wa);
    i_wr_data = DW'(wd);
    i_clear   = clr;
    #1;
    exp_ready = !m_clearing && !rd;
    chk("wr_ready", 32'(o_wr_ready), 32'(exp_ready));

    m_valid = rd;
    if (rd) m_data = (ra < DEP) ? m_mem[ra] : '0;
    m_done = 1'b0;
    if (m_clearing) begin
      if (!rd) begin
        m_mem[m_clr] = CV;
        if (m_clr == DEP - 1) begin
          m_clearing = 1'b0;
          m_done     = 1'b1;
        end else begin
          m_clr++;
        end
      end
    end else begin
      if (wr && exp_ready && wa < DEP) m_mem[wa] = wd[DW-1:0];
      if (clr) begin
        m_clearing = 1'b1;
        m_clr      = 0;
      end
    end
    if (wr && !exp_ready && m_stall < 65535) m_stall++;

    @(posedge i_clk);
    @(negedge i_clk);
    check_regs();
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEP; a++) cyc(1'b1, a, 1'b0, 0, 0, 1'b0);
    idle();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    bit rd;

    i_rst_n = 1'b0; i_rd_req = 1'b0; i_rd_addr = '0; i_wr_req = 1'b0;
    i_wr_addr = '0; i_wr_data = '0; i_clear = 1'b0;
    model_reset();
    #1;
    check_regs();
    chk("reset_wr_ready", 32'(o_wr_ready), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Full clear with no reads: DEPTH busy cycles then a single done pulse
    cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      idle();
    end
    chk("clear_busy_cycles", 32'(n), 32'd16);
    chk("clear_done_seen", 32'(o_clear_done), 32'd1);
    idle();
    read_all();

    // Write then read on the next cycle
    cyc(1'b0, 0, 1'b1, 5, 'hABC, 1'b0);
    cyc(1'b1, 5, 1'b0, 0, 0, 1'b0);
    chk("rd_after_wr_valid", 32'(o_rd_valid), 32'd1);
    chk("rd_after_wr_data", 32'(o_rd_data), 32'hABC);

    // Read and write contending for 3 cycles: write never lands
    repeat (3) cyc(1'b1, 7, 1'b1, 7, 'h123, 1'b0);
`ifdef FB_SRAM_STATS_EN
    chk("stall_after_contention", 32'(o_wr_stall_cnt), 32'd3);
`endif
    cyc(1'b1, 7, 1'b0, 0, 0, 1'b0);
    chk("contention_no_write", 32'(o_rd_data), 32'(CV));

    // Out-of-range read and write
    cyc(1'b1, 16, 1'b0, 0, 0, 1'b0);
    chk("oob_rd_valid", 32'(o_rd_valid), 32'd1);
    chk("oob_rd_data", 32'(o_rd_data), 32'd0);
    cyc(1'b0, 0, 1'b1, 16, 'hFFF, 1'b0);
    read_all();

    // Clear with 4 interleaved reads: DEPTH+4 busy cycles
    cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
    n = 0;
    k = 0;
    while (o_busy && n < 100) begin
      rd = (n % 4 == 1) && (k < 4);
      if (rd) k++;
      cyc(rd, $urandom_range(0, DEP - 1), 1'b1, $urandom_range(0, DEP - 1), $urandom, 1'b0);
      n++;
    end
    chk("clear_with_reads_cycles", 32'(n), 32'd20);
    read_all();

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 1) == 1,
          $urandom_range(0, 31), $urandom, $urandom_range(0, 49) == 0);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      idle();
    end
    chk("random_drain", 32'(o_busy), 32'd0);
    read_all();

    // Reset during clear cycle 7: immediate abort, no done pulse afterwards
    cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
    repeat (6) idle();
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("midclear_busy", 32'(o_busy), 32'd0);
    chk("midclear_wr_ready", 32'(o_wr_ready), 32'd0);
    check_regs();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (20) idle();
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
